// File: rtl/mc_pkg.sv
// Shared opcodes, funct codes, ALU function codes and controller state encoding.
package mc_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_FUNC_W = 3;
  localparam int unsigned ALU_OP_W   = 2;

  // Opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU function codes
  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT = 3'b010;
  localparam logic [ALU_FUNC_W-1:0] ALU_EQL = 3'b011;
  localparam logic [ALU_FUNC_W-1:0] ALU_NEQ = 3'b100;

  // Operation class handed from the controller to the ALU decoder
  typedef enum logic [ALU_OP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_e;

  // True for the R-type funct codes the datapath implements; others are NOPs.
  function automatic logic funct_valid(input logic [FUNCT_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an operation class (and the R-type funct field) to an ALU function code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct_i,
  input  logic [ALU_OP_W-1:0]   alu_op_i,
  output logic [ALU_FUNC_W-1:0] alu_func_o
);

  // Class decode; unimplemented funct codes fall back to add (never reached in RTEX).
  always_comb begin
    alu_func_o = ALU_ADD;
    case (aluop_e'(alu_op_i))
      ALUOP_ADD: alu_func_o = ALU_ADD;
      ALUOP_SUB: alu_func_o = ALU_SUB;
      ALUOP_SLT: alu_func_o = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_func_o = ALU_ADD;
          FN_SUB:  alu_func_o = ALU_SUB;
          FN_SLT:  alu_func_o = ALU_SLT;
          default: alu_func_o = ALU_ADD;
        endcase
      end
      default: alu_func_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset main controller: Moore-decoded datapath controls,
// with branch PCWrite following Zero combinationally.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  Zero,
  output logic [ALU_FUNC_W-1:0] ALUFunc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic                  PCWrite,
  output logic                  IorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  instr_done
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  state_e             state_cur;
  aluop_e             alu_op;

  assign state_cur = state_e'(state_q);

  alu_decoder u_alu_decoder (
    .funct_i    (funct),
    .alu_op_i   (alu_op),
    .alu_func_o (ALUFunc)
  );

  // State register; reset returns to FETCH without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_W'(FETCH);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; write enables are forced low while in reset.
  always_comb begin
    state_d    = STATE_W'(FETCH);
    alu_op     = ALUOP_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    instr_done = 1'b0;

    case (state_cur)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        state_d = STATE_W'(DECODE);
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:     state_d = STATE_W'(MEMADR);
          OP_BEQ, OP_BNE:   state_d = STATE_W'(BRANCH);
          OP_ADDI, OP_SLTI: state_d = STATE_W'(IMMEX);
          OP_J:             state_d = STATE_W'(JUMP);
          OP_RTYPE: begin
            if (funct_valid(funct)) begin
              state_d = STATE_W'(RTEX);
            end else begin
              state_d    = STATE_W'(FETCH);
              instr_done = 1'b1;
            end
          end
          default: begin
            state_d    = STATE_W'(FETCH);
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW) begin
          state_d = STATE_W'(MEMRD);
        end else if (opcode == OP_SW) begin
          state_d = STATE_W'(MEMWR);
        end else begin
          state_d = STATE_W'(FETCH);
        end
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = STATE_W'(MEMWB);
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      RTEX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = STATE_W'(RTWB);
      end
      RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_op     = ALUOP_SUB;
        PCSrc      = 2'b01;
        PCWrite    = (opcode == OP_BNE) ? ~Zero : Zero;
        instr_done = 1'b1;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        state_d = STATE_W'(IMMWB);
      end
      IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = STATE_W'(FETCH);
    endcase

    if (rst) begin
      PCWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: STATE_W, 4, width of the state register.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26], held stable by the IR after FETCH.
REQ-005 funct  in  6  IR[5:0].
REQ-006 Zero  in  1  zero flag from the ALU.
REQ-007 ALUFunc  out  3  add=000, sub=001, slt=010, eql=011, neq=100.
REQ-008 ALUSrcA  out  1  0=PC, 1=register A.
REQ-009 ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg  out  1 each  datapath enables/selects.
REQ-012 instr_done  out  1  one-cycle pulse in the last cycle of every instruction.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BRANCH, IMMEX, IMMWB, JUMP; outputs are Moore-decoded from state, except PCWrite in BRANCH; unlisted outputs are 0.
REQ-014 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUFunc=add, PCSrc=00, PCWrite=1; next state DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUFunc=add. Next state by opcode: 100011/101011 -> MEMADR; 000000 with a valid funct -> RTEX; 000100/000101 -> BRANCH; 001000/001010 -> IMMEX; 000010 -> JUMP; anything else -> FETCH.
REQ-016 R-type funct: 100000=add, 100010=sub, 101010=slt; any other funct in DECODE SHALL act as NOP and go to FETCH.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, add; -> MEMRD for lw, -> MEMWR for sw.
REQ-018 MEMRD: MemRead=1, IorD=1; -> MEMWB.
REQ-019 MEMWB: RegWrite=1, RegDst=0, MemToReg=1; -> FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; -> FETCH.
REQ-021 RTEX: ALUSrcA=1, ALUSrcB=00, ALUFunc=decoded funct; -> RTWB.
REQ-022 RTWB: RegWrite=1, RegDst=1, MemToReg=0; -> FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUFunc=sub, PCSrc=01. PCWrite=Zero for beq and ~Zero for bne, combinational on Zero; -> FETCH.
REQ-024 IMMEX: ALUSrcA=1, ALUSrcB=10, ALUFunc=add (addi) or slt (slti); -> IMMWB.
REQ-025 IMMWB: RegWrite=1, RegDst=0, MemToReg=0; -> FETCH.
REQ-026 JUMP: PCSrc=10, PCWrite=1; -> FETCH.
REQ-027 instr_done=1 in MEMWB, MEMWR, RTWB, BRANCH, IMMWB and JUMP, and in DECODE when it takes the NOP path.
REQ-028 Latency in cycles: lw 5; sw, R-type, addi and slti 4; beq, bne and j 3; NOP 2.
REQ-029 Opcode and funct SHALL be sampled only in DECODE, MEMADR, RTEX, BRANCH and IMMEX, never in FETCH.

Reset
REQ-030 rst high SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-031 While rst is high, every write enable (PCWrite, MemWrite, IRWrite, RegWrite, MemRead) and instr_done SHALL be 0.
REQ-032 The first FETCH SHALL occur on the first rising edge after rst deasserts.
REQ-033 Reset in any state, mid-instruction included, SHALL abandon the instruction with no further writes.

Structure
REQ-034 Shared package mc_pkg SHALL hold the opcode constants, funct constants, ALU function codes (matching REQ-007) and the state enum.
REQ-035 Funct-to-ALUFunc mapping SHALL live in sub-module alu_decoder (combinational, funct plus a 2-bit op class in, 3-bit ALUFunc out).

Verification
REQ-036 Reset: assert rst while in DECODE -> state=FETCH asynchronously, all enables 0; after release, PCWrite=1 and IRWrite=1 in the first cycle.
REQ-037 add (opcode 000000, funct 100000): FETCH, DECODE, RTEX (ALUFunc=000), RTWB (RegWrite=1, RegDst=1); instr_done in cycle 4.
REQ-038 lw (100011): MEMRD has MemRead=1 and IorD=1; MEMWB has RegWrite=1 and MemToReg=1; instr_done in cycle 5.
REQ-039 beq (000100) with Zero=1 in BRANCH: PCWrite=1, PCSrc=01, ALUFunc=001. Same with Zero=0: PCWrite=0. bne with Zero=0: PCWrite=1.
REQ-040 slti (001010): IMMEX has ALUFunc=010 and ALUSrcB=10; IMMWB has RegWrite=1 and RegDst=0.
REQ-041 Opcode 111111, or opcode 000000 with funct 000111: DECODE goes to FETCH with instr_done=1; no RegWrite or MemWrite at any point.
